// File: rtl/ranger_pkg.sv
// rtl/ranger_pkg.sv - shared types and default timing for the ranging, conversion and display stages
package ranger_pkg;

    localparam int DATA_W = 19;
    localparam int CNT_W  = 23;

    localparam int DEF_TRIG_CYCLES     = 1000;
    localparam int DEF_CYCLES_PER_UNIT = 583;
    localparam int DEF_ECHO_WAIT_MAX   = 3000000;
    localparam int DEF_MAX_UNITS       = 4000;
    localparam int DEF_PERIOD_CYCLES   = 6000000;

    typedef enum logic [2:0] {
        IDLE,
        TRIG,
        WAIT_ECHO,
        MEASURE,
        HOLDOFF
    } state_t;

endpackage

// File: rtl/echo_sync.sv
// rtl/echo_sync.sv - two-flop echo synchronizer with rise/fall pulses
module echo_sync (
    input  logic clk,
    input  logic rst,
    input  logic echo,
    output logic level,
    output logic rise,
    output logic fall
);

    logic s1, s2, s3;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= echo;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // level lags the edge pulses by one cycle so a counter started on rise sees every high cycle
    assign level = s3;
    assign rise  = s2 & ~s3;
    assign fall  = ~s2 & s3;

endmodule

// File: rtl/ultrasonic_ranger.sv
// rtl/ultrasonic_ranger.sv - HC-SR04 trigger generation and echo pulse-width ranging in mm
module ultrasonic_ranger
    import ranger_pkg::*;
#(
    parameter int TRIG_CYCLES     = DEF_TRIG_CYCLES,
    parameter int CYCLES_PER_UNIT = DEF_CYCLES_PER_UNIT,
    parameter int ECHO_WAIT_MAX   = DEF_ECHO_WAIT_MAX,
    parameter int MAX_UNITS       = DEF_MAX_UNITS,
    parameter int PERIOD_CYCLES   = DEF_PERIOD_CYCLES
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              echo,
    output logic              trig,
    output logic [DATA_W-1:0] data_out,
    output logic              valid,
    output logic              timeout
);

    localparam int TICK_W = (CYCLES_PER_UNIT > 1) ? $clog2(CYCLES_PER_UNIT) : 1;

    localparam logic [CNT_W-1:0]  TRIG_LAST   = CNT_W'(TRIG_CYCLES - 1);
    localparam logic [CNT_W-1:0]  WAIT_LAST   = CNT_W'(ECHO_WAIT_MAX - 1);
    localparam logic [CNT_W-1:0]  PERIOD_LAST = CNT_W'(PERIOD_CYCLES - 1);
    localparam logic [TICK_W-1:0] TICK_LAST   = TICK_W'(CYCLES_PER_UNIT - 1);
    localparam logic [DATA_W-1:0] MAX_U       = DATA_W'(MAX_UNITS);

    state_t            state, state_next;
    logic [CNT_W-1:0]  cnt, period;
    logic [TICK_W-1:0] tick;
    logic [DATA_W-1:0] units, units_inc, report_val;
    logic              echo_level, echo_rise, echo_fall;
    logic              tick_wrap, sat_hit, report, report_sat;

    echo_sync u_echo_sync (
        .clk   (clk),
        .rst   (rst),
        .echo  (echo),
        .level (echo_level),
        .rise  (echo_rise),
        .fall  (echo_fall)
    );

    always_comb begin
        tick_wrap  = echo_level && (tick == TICK_LAST);
        units_inc  = units + DATA_W'(tick_wrap);
        sat_hit    = (units_inc >= MAX_U);
        state_next = state;
        report     = 1'b0;
        report_sat = 1'b0;
        report_val = units_inc;
        case (state)
            IDLE: begin
                if (en) state_next = TRIG;
            end
            TRIG: begin
                if (cnt == TRIG_LAST) state_next = WAIT_ECHO;
            end
            WAIT_ECHO: begin
                if (echo_rise) begin
                    state_next = MEASURE;
                end else if (cnt == WAIT_LAST) begin
                    report     = 1'b1;
                    report_sat = 1'b1;
                    report_val = MAX_U;
                    state_next = HOLDOFF;
                end
            end
            MEASURE: begin
                // saturation wins over a fall landing on the same cycle
                if (sat_hit) begin
                    report     = 1'b1;
                    report_sat = 1'b1;
                    report_val = MAX_U;
                    state_next = HOLDOFF;
                end else if (echo_fall) begin
                    report     = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: begin
                if (period >= PERIOD_LAST) state_next = en ? TRIG : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            period   <= '0;
            tick     <= '0;
            units    <= '0;
            trig     <= 1'b0;
            data_out <= '0;
            valid    <= 1'b0;
            timeout  <= 1'b0;
        end else begin
            state   <= state_next;
            trig    <= (state_next == TRIG);
            valid   <= report;
            timeout <= report_sat;
            if (report) data_out <= report_val;

            if ((state_next != state) || !((state == TRIG) || (state == WAIT_ECHO)))
                cnt <= '0;
            else
                cnt <= cnt + CNT_W'(1);

            if ((state_next == TRIG) && (state != TRIG))
                period <= '0;
            else if (period != '1)
                period <= period + CNT_W'(1);

            if (state != MEASURE) begin
                tick  <= '0;
                units <= '0;
            end else if (echo_level) begin
                tick  <= tick_wrap ? '0 : tick + TICK_W'(1);
                units <= sat_hit ? MAX_U : units_inc;
            end
        end
    end

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// tb/tb_ultrasonic_ranger.sv - directed self-checking bench for ultrasonic_ranger
module tb_ultrasonic_ranger;

    logic        clk = 1'b0;
    logic        rst, en, echo, echo_s;
    logic        trig, valid, timeout;
    logic [18:0] data_out;
    logic        trig_s, valid_s, timeout_s;
    logic [18:0] data_s;

    int n_pass = 0;
    int n_chk  = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    ultrasonic_ranger #(
        .TRIG_CYCLES(10), .CYCLES_PER_UNIT(5), .ECHO_WAIT_MAX(200),
        .MAX_UNITS(4000), .PERIOD_CYCLES(2000)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .echo(echo),
        .trig(trig), .data_out(data_out), .valid(valid), .timeout(timeout)
    );

    ultrasonic_ranger #(
        .TRIG_CYCLES(10), .CYCLES_PER_UNIT(5), .ECHO_WAIT_MAX(200),
        .MAX_UNITS(100), .PERIOD_CYCLES(2000)
    ) dut_sat (
        .clk(clk), .rst(rst), .en(en), .echo(echo_s),
        .trig(trig_s), .data_out(data_s), .valid(valid_s), .timeout(timeout_s)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return trig;
            1:       return valid;
            2:       return trig_s;
            3:       return valid_s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic wait_sig(input int sel, input logic lvl, input int budget,
                            input string tag, output int n);
        n = 0;
        while (pick(sel) !== lvl && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (pick(sel) !== lvl) check({tag, " bound"}, 32'(pick(sel)), 32'(lvl));
    endtask

    task automatic measure(input int width, input int exp, input string tag);
        int n;
        wait_sig(0, 1'b1, 2500, {tag, " trig rise"}, n);
        wait_sig(0, 1'b0, 20, {tag, " trig fall"}, n);
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (width) @(negedge clk);
        echo = 1'b0;
        wait_sig(1, 1'b1, 50, {tag, " valid"}, n);
        check({tag, " data"}, 32'(data_out), exp);
        check({tag, " timeout"}, 32'(timeout), 0);
        @(negedge clk);
        check({tag, " valid pulse"}, 32'(valid), 0);
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n, t0, hits;
        rst = 1'b1; en = 1'b1; echo = 1'b0; echo_s = 1'b0;
        repeat (3) @(negedge clk);
        check("reset trig", 32'(trig), 0);
        check("reset data", 32'(data_out), 0);
        check("reset valid", 32'(valid), 0);
        check("reset timeout", 32'(timeout), 0);
        rst = 1'b0;

        wait_sig(0, 1'b1, 5, "first trig", n);
        check("first trig latency", n, 1);
        wait_sig(0, 1'b0, 100, "first trig fall", n);
        check("trig width", n, 10);

        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (650) @(negedge clk);
        echo = 1'b0;
        wait_sig(1, 1'b1, 50, "nominal valid", n);
        check("nominal data", 32'(data_out), 130);
        check("nominal timeout", 32'(timeout), 0);
        @(negedge clk);
        check("nominal valid pulse", 32'(valid), 0);
        check("nominal data hold", 32'(data_out), 130);

        measure(654, 130, "trunc654");
        measure(655, 131, "trunc655");

        wait_sig(0, 1'b1, 2500, "noecho trig", n);
        t0 = cyc;
        wait_sig(0, 1'b0, 20, "noecho trig fall", n);
        wait_sig(1, 1'b1, 400, "noecho valid", n);
        check("noecho latency", n, 200);
        check("noecho data", 32'(data_out), 4000);
        check("noecho timeout", 32'(timeout), 1);
        @(negedge clk);
        check("noecho timeout pulse", 32'(timeout), 0);
        wait_sig(0, 1'b1, 2500, "period trig", n);
        check("trig period", cyc - t0, 2000);

        wait_sig(0, 1'b0, 20, "pre-stuck fall", n);
        wait_sig(1, 1'b1, 400, "pre-stuck valid", n);
        echo = 1'b1;
        wait_sig(0, 1'b1, 2500, "stuck trig", n);
        wait_sig(0, 1'b0, 20, "stuck trig fall", n);
        wait_sig(1, 1'b1, 400, "stuck valid", n);
        check("stuck latency", n, 200);
        check("stuck data", 32'(data_out), 4000);
        check("stuck timeout", 32'(timeout), 1);
        echo = 1'b0;

        wait_sig(0, 1'b1, 2500, "en-drop trig", n);
        wait_sig(0, 1'b0, 20, "en-drop trig fall", n);
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (100) @(negedge clk);
        en = 1'b0;
        repeat (200) @(negedge clk);
        echo = 1'b0;
        wait_sig(1, 1'b1, 50, "en-drop valid", n);
        check("en-drop data", 32'(data_out), 60);
        check("en-drop timeout", 32'(timeout), 0);
        hits = 0;
        repeat (2500) begin
            @(negedge clk);
            if (trig) hits++;
        end
        check("parked no trig", hits, 0);
        en = 1'b1;
        wait_sig(0, 1'b1, 5, "resume trig", n);
        check("resume latency", n, 1);

        wait_sig(0, 1'b0, 20, "rst-mid trig fall", n);
        repeat (20) @(negedge clk);
        echo = 1'b1;
        repeat (50) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("rst-mid trig", 32'(trig), 0);
        check("rst-mid data", 32'(data_out), 0);
        check("rst-mid valid", 32'(valid), 0);
        echo = 1'b0;
        rst = 1'b0;
        wait_sig(0, 1'b1, 5, "post-rst trig", n);
        check("post-rst latency", n, 1);

        wait_sig(2, 1'b1, 2500, "sat trig", n);
        wait_sig(2, 1'b0, 20, "sat trig fall", n);
        repeat (20) @(negedge clk);
        echo_s = 1'b1;
        wait_sig(3, 1'b1, 1100, "sat valid", n);
        check("sat latency", n, 503);
        check("sat data", 32'(data_s), 100);
        check("sat timeout", 32'(timeout_s), 1);
        repeat (1000 - n) @(negedge clk);
        echo_s = 1'b0;
        hits = 0;
        repeat (600) begin
            @(negedge clk);
            if (trig_s || valid_s) hits++;
        end
        check("sat holdoff quiet", hits, 0);
        check("sat data hold", 32'(data_s), 100);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
